// File: rtl/sp_fifo_pkg.sv
// Shared types and defaults for the single-port FIFO: the conflict-policy enum,
// the res source selector and a helper that resolves which side wins a conflict.
package sp_fifo_pkg;

  typedef enum logic [1:0] {
    PRIO_WR  = 2'd0,
    PRIO_RD  = 2'd1,
    PRIO_ALT = 2'd2
  } prio_e;

  typedef enum logic [1:0] {
    RES_ZERO = 2'd0,
    RES_RAM  = 2'd1,
    RES_BYP  = 2'd2
  } res_src_e;

  localparam int SP_FIFO_W     = 32;
  localparam int SP_FIFO_DEPTH = 8;

  // alt_toggle=0 favours the write, so the first alternate conflict goes to the writer
  function automatic logic favour_write(input prio_e mode, input logic alt_toggle);
    case (mode)
      PRIO_WR: return 1'b1;
      PRIO_RD: return 1'b0;
      default: return ~alt_toggle;
    endcase
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM, one access per cycle, registered read (1-cycle latency).
// dout only changes on a read access, so it holds the last word read.
module sp_ram
  import sp_fifo_pkg::*;
#(
  parameter int W     = SP_FIFO_W,
  parameter int DEPTH = SP_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] dout_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout_reg  <= mem[addr];
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/sp_fifo_param.sv
// FIFO built on one single-port RAM; write and read contend for the port per PRIO.
// Optional macro SP_FIFO_BYPASS_EN: on an empty FIFO, we&re passes din straight to res.
module sp_fifo_param
  import sp_fifo_pkg::*;
#(
  parameter int W     = SP_FIFO_W,
  parameter int DEPTH = SP_FIFO_DEPTH,
  parameter int PRIO  = 0,
  parameter int AF_TH = DEPTH - 1,
  parameter int AE_TH = 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W+1:0]  inst,
  output logic [W-1:0]  res,
  output logic          read_valid,
  output logic          wr_ack,
  output logic          rd_ack,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          conflict
);

  localparam int AW = $clog2(DEPTH);
  localparam prio_e PRIO_MODE = prio_e'(PRIO[1:0]);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef SP_FIFO_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic          we;
  logic          re;
  logic [W-1:0]  din;
  logic          wr_req;
  logic          rd_req;
  logic          fav_wr;
  logic          bypass;
  logic          wr_grant;
  logic          rd_grant;
  logic          wr_store;
  logic [W-1:0]  ram_dout;

  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [CW-1:0] count_reg;
  logic          alt_reg;
  logic          read_valid_reg;
  res_src_e      res_src_reg;
  logic [W-1:0]  byp_data_reg;

  assign we  = inst[W+1];
  assign re  = inst[W];
  assign din = inst[W-1:0];

  // Requests are gated by rst so acks and conflict drop asynchronously in reset
  assign wr_req   = rst & we & ~full;
  assign rd_req   = rst & re & ~empty;
  assign fav_wr   = favour_write(PRIO_MODE, alt_reg);
  assign bypass   = BYPASS & rst & empty & we & re;
  assign wr_grant = wr_req & (~rd_req | fav_wr);
  assign rd_grant = rd_req & (~wr_req | ~fav_wr);
  assign wr_store = wr_grant & ~bypass;

  assign wr_ack   = wr_grant;
  assign rd_ack   = rd_grant | bypass;
  assign conflict = wr_req & rd_req & ~bypass;

  sp_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (wr_store | rd_grant),
    .we   (wr_store),
    .addr (wr_store ? wptr_reg : rptr_reg),
    .din  (din),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      count_reg      <= '0;
      alt_reg        <= 1'b0;
      read_valid_reg <= 1'b0;
      res_src_reg    <= RES_ZERO;
      byp_data_reg   <= '0;
    end else begin
      if (wr_store) wptr_reg <= wptr_reg + 1'b1;
      if (rd_grant) rptr_reg <= rptr_reg + 1'b1;
      if (wr_store)      count_reg <= count_reg + 1'b1;
      else if (rd_grant) count_reg <= count_reg - 1'b1;
      if (wr_req & rd_req) alt_reg <= ~alt_reg;
      read_valid_reg <= rd_grant | bypass;
      if (rd_grant) begin
        res_src_reg <= RES_RAM;
      end else if (bypass) begin
        res_src_reg  <= RES_BYP;
        byp_data_reg <= din;
      end
    end
  end

  // res follows whichever source produced the most recent read; RAM dout holds between reads
  always_comb begin
    res = '0;
    case (res_src_reg)
      RES_RAM: res = ram_dout;
      RES_BYP: res = byp_data_reg;
      default: res = '0;
    endcase
  end

  assign read_valid   = read_valid_reg;
  assign count        = count_reg;
  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (int'(count_reg) >= AF_TH);
  assign almost_empty = (int'(count_reg) <= AE_TH);

endmodule

// File: tb/tb_sp_fifo_param.sv
// Self-checking bench: one write-first instance and one alternate-policy instance,
// table-driven vectors plus hand sequences for reset-mid-read and the empty we&re case.
module tb_sp_fifo_param;

  typedef struct {
    bit          sel;
    bit          we;
    bit          re;
    logic [31:0] din;
    bit          ew;
    bit          er;
    bit          ecf;
    bit          byp;
    int          ecnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [33:0] inst0, inst2;
  logic [31:0] res0, res2;
  logic        rv0, rv2, wack0, wack2, rack0, rack2;
  logic        full0, full2, empty0, empty2, af0, af2, ae0, ae2, cf0, cf2;
  logic [3:0]  cnt0, cnt2;

  sp_fifo_param #(.W(32), .DEPTH(8), .PRIO(0)) u_dut0 (
    .clk(clk), .rst(rst), .inst(inst0), .res(res0), .read_valid(rv0),
    .wr_ack(wack0), .rd_ack(rack0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .conflict(cf0)
  );

  sp_fifo_param #(.W(32), .DEPTH(8), .PRIO(2)) u_dut2 (
    .clk(clk), .rst(rst), .inst(inst2), .res(res2), .read_valid(rv2),
    .wr_ack(wack2), .rd_ack(rack2), .full(full2), .empty(empty2),
    .almost_full(af2), .almost_empty(ae2), .count(cnt2), .conflict(cf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          sel;
  logic [31:0] o_res;
  logic        o_rv, o_wack, o_rack, o_full, o_empty, o_af, o_ae, o_cf;
  logic [3:0]  o_cnt;

  always_comb begin
    o_res   = sel ? res2   : res0;
    o_rv    = sel ? rv2    : rv0;
    o_wack  = sel ? wack2  : wack0;
    o_rack  = sel ? rack2  : rack0;
    o_full  = sel ? full2  : full0;
    o_empty = sel ? empty2 : empty0;
    o_af    = sel ? af2    : af0;
    o_ae    = sel ? ae2    : ae0;
    o_cf    = sel ? cf2    : cf0;
    o_cnt   = sel ? cnt2   : cnt0;
  end

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];
  logic [31:0] data_q[$];
  logic [31:0] res_q[$];
  logic [31:0] lres [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void add(bit s, bit we, bit re, logic [31:0] din,
                              bit ew, bit er, bit cf, int cnt, bit byp = 1'b0);
    vec_t v;
    v.sel = s; v.we = we; v.re = re; v.din = din;
    v.ew = ew; v.er = er; v.ecf = cf; v.ecnt = cnt; v.byp = byp;
    vecs.push_back(v);
  endfunction

  // Called at posedge+1: drive, compare at the falling edge, update the model, advance.
  task automatic apply(input vec_t v);
    logic [31:0] exp_res;
    sel = v.sel;
    inst0 = v.sel ? 34'd0 : {v.we, v.re, v.din};
    inst2 = v.sel ? {v.we, v.re, v.din} : 34'd0;
    #4;
    if (res_q.size() > 0) begin
      exp_res = res_q.pop_front();
      chk("read_valid", {31'd0, o_rv}, 32'd1);
      chk("res", o_res, exp_res);
      lres[v.sel] = exp_res;
    end else begin
      chk("read_valid", {31'd0, o_rv}, 32'd0);
      chk("res_hold", o_res, lres[v.sel]);
    end
    chk("wr_ack", {31'd0, o_wack}, {31'd0, v.ew});
    chk("rd_ack", {31'd0, o_rack}, {31'd0, v.er});
    chk("conflict", {31'd0, o_cf}, {31'd0, v.ecf});
    chk("count", {28'd0, o_cnt}, v.ecnt);
    chk("full", {31'd0, o_full}, {31'd0, (v.ecnt == 8)});
    chk("empty", {31'd0, o_empty}, {31'd0, (v.ecnt == 0)});
    chk("almost_full", {31'd0, o_af}, {31'd0, (v.ecnt >= 7)});
    chk("almost_empty", {31'd0, o_ae}, {31'd0, (v.ecnt <= 1)});
    $display("t=%0t dut=%0d we=%b re=%b din=%h wack=%b rack=%b cf=%b cnt=%0d rv=%b res=%h",
             $time, v.sel ? 2 : 0, v.we, v.re, v.din, o_wack, o_rack, o_cf, o_cnt, o_rv, o_res);
    if (v.byp) begin
      res_q.push_back(v.din);
    end else begin
      if (v.ew) data_q.push_back(v.din);
      if (v.er) begin
        if (data_q.size() > 0) res_q.push_back(data_q.pop_front());
        else res_q.push_back(32'hxxxx_xxxx);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;

    // Write 1..9 into PRIO=0 instance; the 9th is refused by full
    for (int i = 1; i <= 9; i++)
      add(0, 1, 0, 32'(i), i <= 8, 0, 0, (i <= 8) ? i - 1 : 8);
    // Read-only drain; the 9th read is refused by empty
    for (int i = 1; i <= 9; i++)
      add(0, 0, 1, 32'h0, 0, i <= 8, 0, (i <= 8) ? 9 - i : 0);
    add(0, 0, 0, 32'h0, 0, 0, 0, 0);
    // Refill, then hold we&re while full under write-first policy
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 32'hA0 + 32'(i), 1, 0, 0, i - 1);
    for (int k = 0; k < 4; k++)
      add(0, 1, 1, 32'hB0 + 32'(k), k[0], !k[0], k[0], k[0] ? 7 : 8);
    for (int i = 1; i <= 9; i++)
      add(0, 0, 1, 32'h0, 0, i <= 8, 0, (i <= 8) ? 9 - i : 0);
    add(0, 0, 0, 32'h0, 0, 0, 0, 0);
    // Alternate policy: fill 4, then we&re grants W,R,W,R...
    for (int i = 1; i <= 4; i++)
      add(1, 1, 0, 32'hD0 + 32'(i), 1, 0, 0, i - 1);
    for (int k = 0; k < 6; k++)
      add(1, 1, 1, 32'hE0 + 32'(k), !k[0], k[0], 1, k[0] ? 5 : 4);
    for (int i = 1; i <= 5; i++)
      add(1, 0, 1, 32'h0, 0, i <= 4, 0, (i <= 4) ? 5 - i : 0);
    add(1, 0, 0, 32'h0, 0, 0, 0, 0);

    // Reset: outputs forced even with a we&re command present
    sel = 0;
    rst = 1'b0;
    inst0 = {1'b1, 1'b1, 32'h1234_5678};
    inst2 = {1'b1, 1'b1, 32'h1234_5678};
    lres[0] = 32'h0;
    lres[1] = 32'h0;
    #2;
    chk("rst_res", res0, 32'h0);
    chk("rst_read_valid", {31'd0, rv0}, 32'd0);
    chk("rst_count", {28'd0, cnt0}, 32'd0);
    chk("rst_empty", {31'd0, empty0}, 32'd1);
    chk("rst_almost_empty", {31'd0, ae0}, 32'd1);
    chk("rst_full", {31'd0, full0}, 32'd0);
    chk("rst_almost_full", {31'd0, af0}, 32'd0);
    chk("rst_wr_ack", {31'd0, wack0}, 32'd0);
    chk("rst_rd_ack", {31'd0, rack0}, 32'd0);
    chk("rst_conflict", {31'd0, cf2}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    inst0 = 34'd0;
    inst2 = 34'd0;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i]);

    // Reset asserted while a read result is in flight
    v = '{sel: 0, we: 1, re: 0, din: 32'h1111_0001, ew: 1, er: 0, ecf: 0, byp: 0, ecnt: 0};
    apply(v);
    v.din = 32'h1111_0002; v.ecnt = 1;
    apply(v);
    v = '{sel: 0, we: 0, re: 1, din: 32'h0, ew: 0, er: 1, ecf: 0, byp: 0, ecnt: 2};
    apply(v);
    chk("inflight_read_valid", {31'd0, rv0}, 32'd1);
    chk("inflight_res", res0, 32'h1111_0001);
    res_q.delete();
    data_q.delete();
    rst = 1'b0;
    #1;
    chk("midrst_read_valid", {31'd0, rv0}, 32'd0);
    chk("midrst_count", {28'd0, cnt0}, 32'd0);
    chk("midrst_empty", {31'd0, empty0}, 32'd1);
    chk("midrst_res", res0, 32'h0);
    chk("midrst_rd_ack", {31'd0, rack0}, 32'd0);
    $display("t=%0t reset mid-read rv=%b cnt=%0d empty=%b res=%h", $time, rv0, cnt0, empty0, res0);
    #2;
    inst0 = 34'd0;
    rst = 1'b1;
    lres[0] = 32'h0;
    lres[1] = 32'h0;
    @(posedge clk);
    #1;

    // Empty FIFO with we&re
`ifdef SP_FIFO_BYPASS_EN
    v = '{sel: 0, we: 1, re: 1, din: 32'h55, ew: 1, er: 1, ecf: 0, byp: 1, ecnt: 0};
    apply(v);
    v = '{sel: 0, we: 0, re: 0, din: 32'h0, ew: 0, er: 0, ecf: 0, byp: 0, ecnt: 0};
    apply(v);
    apply(v);
`else
    v = '{sel: 0, we: 1, re: 1, din: 32'h55, ew: 1, er: 0, ecf: 0, byp: 0, ecnt: 0};
    apply(v);
    v = '{sel: 0, we: 0, re: 0, din: 32'h0, ew: 0, er: 0, ecf: 0, byp: 0, ecnt: 1};
    apply(v);
    v = '{sel: 0, we: 0, re: 1, din: 32'h0, ew: 0, er: 1, ecf: 0, byp: 0, ecnt: 1};
    apply(v);
    v = '{sel: 0, we: 0, re: 0, din: 32'h0, ew: 0, er: 0, ecf: 0, byp: 0, ecnt: 0};
    apply(v);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_fifo_param.md
SP_FIFO_PARAM -- requirements
Module: sp_fifo_param

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- W, 32, data width.
- DEPTH, 8, entries; power of 2, ≥2.
- PRIO, 0, conflict policy: 0 = write-first, 1 = read-first, 2 = alternate.
- AF_TH, DEPTH-1, almost-full threshold.
- AE_TH, 1, almost-empty threshold.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning (CW = $clog2(DEPTH+1)):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst  in  W+2  packed command {we, re, din}.
- res  out  W  read data.
- read_valid  out  1  res valid this cycle.
- wr_ack  out  1  write granted this cycle.
- rd_ack  out  1  read granted this cycle.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- almost_full  out  1  count ≥ AF_TH.
- almost_empty  out  1  count ≤ AE_TH.
- count  out  CW  occupancy.
- conflict  out  1  we/re contention this cycle.

Function
REQ-003 Command fields SHALL decode as we=inst[W+1], re=inst[W], din=inst[W-1:0].
REQ-004 Request terms SHALL be wr_req = we & !full and rd_req = re & !empty.
REQ-005 Storage SHALL be one single-port RAM performing at most one access per cycle.
REQ-006 Arbitration SHALL be:
- A single request is granted.
- When both requests are active, exactly one is granted per PRIO.
- PRIO=2 favours write on the first conflict after reset, then flips the favoured side after each conflict.
REQ-007 wr_ack/rd_ack SHALL be combinational, same cycle as the request.
REQ-008 A rejected requester SHALL hold inst; the block stores no pending request.
REQ-009 A granted write SHALL:
- Store din at wptr.
- Advance wptr modulo DEPTH.
- Increment count.
REQ-010 A granted read SHALL:
- Read rptr and advance rptr modulo DEPTH.
- Decrement count.
- Present data on res one cycle later with read_valid=1 for exactly that cycle.
REQ-011 res SHALL hold its last value while read_valid=0.
REQ-012 Status flags SHALL derive from registered count: full = (count==DEPTH), empty = (count==0), almost_full = (count≥AF_TH), almost_empty = (count≤AE_TH).
REQ-013 conflict SHALL be high exactly when wr_req & rd_req and no bypass (REQ-017) applies.
REQ-014 A write to a full FIFO SHALL give wr_ack=0 and change no state.
REQ-015 A read from an empty FIFO SHALL give rd_ack=0 and change no state (except REQ-017).
REQ-016 Data SHALL leave in write order across pointer wrap-around.

Configuration
REQ-017 With macro SP_FIFO_BYPASS_EN defined, empty & we & re SHALL:
- Grant both requests.
- Register din to res, with read_valid=1 next cycle.
- Leave RAM, pointers and count unchanged.
REQ-018 Without SP_FIFO_BYPASS_EN, that case SHALL grant only the write (rd_ack=0).

Reset
REQ-019 While rst=0, outputs SHALL asynchronously be:
- res=0, read_valid=0, count=0.
- empty=1, almost_empty=1, full=0, almost_full=0.
- wr_ack=0, rd_ack=0, conflict=0.
REQ-020 While rst=0, pointers and the alternate-toggle SHALL be 0; RAM contents are not reset.
REQ-021 Reset asserted mid-operation SHALL squash any in-flight read_valid immediately.

Structure
REQ-022 Package sp_fifo_pkg SHALL hold the PRIO enum typedef (PRIO_WR, PRIO_RD, PRIO_ALT) and default width/depth constants.
REQ-023 RAM SHALL be sub-module sp_ram: single port, 1-cycle read latency, we/addr/din/dout.

Verification (W=32, DEPTH=8)
REQ-024 Write 1..8 continuously -> wr_ack=1 ×8, count=8, full=1; 9th write gives wr_ack=0 and count stays 8.
REQ-025 Read-only from full -> res=1..8 each one cycle after rd_ack, 8 read_valid pulses, empty=1; 9th read gives rd_ack=0.
REQ-026 Fill 4, hold we&re with PRIO=2 -> grants W,R,W,R…, conflict=1 each cycle, count 4↔5, output order preserved.
REQ-027 Full, hold we&re with PRIO=0 -> read granted (full masks write), then write; count oscillates 8↔7.
REQ-028 Empty, inst={1,1,32'h55} -> with SP_FIFO_BYPASS_EN: both acks, res=32'h55 next cycle, count=0; without: wr_ack=1, rd_ack=0, count=1.
REQ-029 rst=0 during a read -> read_valid=0 and count=0 immediately, empty=1.
